// File: rtl/seven_seg_multiplexer.sv
// seven_seg_multiplexer
//   Multi-digit seven-segment scan engine. A free-running divider produces a
//   scan tick every 2^DIVIDE_BY clocks. Each tick advances the digit index and
//   reloads the registered anode/segment/decimal-point outputs. Display data is
//   taken from shadow registers. These reload only when the index wraps to
//   digit 0, so a frame never mixes old and new values.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN. When it is defined, zero
//   digits from the top digit downward are also darkened, up to the first
//   nonzero digit. Digit 0 is never darkened by this rule.
//
// Parameters
//   NUM_DIGITS  number of multiplexed digits (1..8)
//   DIVIDE_BY   log2 of clocks per digit slot
// Ports
//   clk         board clock
//   reset_n     asynchronous active-low reset
//   digits      hex nibble per digit, digit i at [4i+3:4i], digit 0 rightmost
//   blank       1 = digit dark
//   dp          1 = decimal point lit on that digit
//   freeze      1 = skip shadow reload at the frame wrap
//   an          anodes, active-low (at most one low)
//   seg         segments a..g on bits 0..6, active-low
//   dp_n        decimal point, active-low
//   frame_done  one-cycle pulse on the edge that reloads the shadow
module seven_seg_multiplexer #(
  parameter int NUM_DIGITS = 4,
  parameter int DIVIDE_BY  = 17
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    freeze,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIVIDE_BY-1:0]    div_cnt;
  logic                    tick;
  logic                    wrap;
  logic                    load;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [4*NUM_DIGITS-1:0] sh_digits_nxt;
  logic [NUM_DIGITS-1:0]   sh_blank_nxt;
  logic [NUM_DIGITS-1:0]   sh_dp_nxt;

  logic [NUM_DIGITS-1:0]   lz;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_n_nxt;

  // Hex to active-low segments, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Marks zero digits from the top downward until the first nonzero digit.
  // The loop stops above digit 0, so the last digit always stays visible.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
    logic [NUM_DIGITS-1:0] m;
    logic                  run;
    m   = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (run && (d[4*i +: 4] == 4'h0)) m[i] = 1'b1;
      else                              run  = 1'b0;
    end
    return m;
  endfunction

  // Scan control: tick, next index and frame wrap.
  always_comb begin
    tick = &div_cnt;
    wrap = tick && (idx == LAST_IDX);
    load = wrap && !freeze;
    if (!tick)               idx_nxt = idx;
    else if (idx == LAST_IDX) idx_nxt = '0;
    else                     idx_nxt = idx + 1'b1;
  end

  // Shadow contents as they stand after this edge. The outputs are decoded
  // from these values, so the first slot of a new frame already shows the
  // newly captured data.
  always_comb begin
    sh_digits_nxt = load ? digits : sh_digits;
    sh_blank_nxt  = load ? blank  : sh_blank;
    sh_dp_nxt     = load ? dp     : sh_dp;
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb lz = lz_mask(sh_digits_nxt);
`else
  always_comb lz = '0;
`endif

  // Output decode for the next digit slot.
  always_comb begin
    eff_blank = sh_blank_nxt | lz;
    nibble    = sh_digits_nxt[4*int'(idx_nxt) +: 4];
    if (eff_blank[idx_nxt]) begin
      an_nxt   = '1;
      seg_nxt  = 7'h7F;
      dp_n_nxt = 1'b1;
    end else begin
      an_nxt   = ~(NUM_DIGITS'(1) << idx_nxt);
      seg_nxt  = hex7(nibble);
      dp_n_nxt = ~sh_dp_nxt[idx_nxt];
    end
  end

  // Register stage: divider, index, shadow and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      sh_digits  <= '0;
      sh_blank   <= '1;
      sh_dp      <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
      idx        <= idx_nxt;
      frame_done <= load;
      sh_digits  <= sh_digits_nxt;
      sh_blank   <= sh_blank_nxt;
      sh_dp      <= sh_dp_nxt;
      if (tick) begin
        an   <= an_nxt;
        seg  <= seg_nxt;
        dp_n <= dp_n_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_multiplexer.sv
// Bench for seven_seg_multiplexer with NUM_DIGITS=4 and DIVIDE_BY=2.
// A table holds the directed display vectors. Hand-written sequences cover
// reset, the first dark frame, freeze and asynchronous reset mid-frame.
module tb_seven_seg_multiplexer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic        freeze;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int bad_an   = 0;

  always #5 clk = ~clk;

  seven_seg_multiplexer #(.NUM_DIGITS(4), .DIVIDE_BY(2)) dut (
    .clk(clk), .reset_n(reset_n), .digits(digits), .blank(blank), .dp(dp),
    .freeze(freeze), .an(an), .seg(seg), .dp_n(dp_n), .frame_done(frame_done)
  );

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpn;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Advances to following negedges, counting any cycle with two or more anodes low.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if ($countones(~an) > 1) bad_an++;
    end
  endtask

  // Bounded wait for a frame_done pulse; leaves the bench at the negedge after it.
  task automatic wait_frame(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_frame_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic check_slot(input string name, input logic [3:0] e_an,
                            input logic [6:0] e_seg, input logic e_dpn);
    check({name, "_an"},   32'(an),   32'(e_an));
    check({name, "_seg"},  32'(seg),  32'(e_seg));
    check({name, "_dp_n"}, 32'(dp_n), 32'(e_dpn));
  endtask

  // Runs 16 cycles from reset release. Expects a dark display until the
  // frame wrap at cycle 15, and frame_done only on that cycle.
  task automatic first_frame(input string name);
    int dark_bad;
    int fd_bad;
    dark_bad = 0;
    fd_bad   = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (frame_done !== (k == 15)) fd_bad++;
      if (k < 15 && an !== 4'hF) dark_bad++;
    end
    check({name, "_dark_cycles_bad"}, 32'(dark_bad), 32'd0);
    check({name, "_frame_done_bad"},  32'(fd_bad),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{16'h12AF, 4'b0000, 4'b0100, 0, 4'b1110, 7'b0001110, 1'b1});
    vecs.push_back('{16'h12AF, 4'b0000, 4'b0100, 1, 4'b1101, 7'b0001000, 1'b1});
    vecs.push_back('{16'h12AF, 4'b0000, 4'b0100, 2, 4'b1011, 7'b0100100, 1'b0});
    vecs.push_back('{16'h12AF, 4'b0000, 4'b0100, 3, 4'b0111, 7'b1111001, 1'b1});
    vecs.push_back('{16'h12AF, 4'b1000, 4'b0100, 3, 4'b1111, 7'b1111111, 1'b1});
    vecs.push_back('{16'h12AF, 4'b1000, 4'b0100, 2, 4'b1011, 7'b0100100, 1'b0});
    vecs.push_back('{16'h3456, 4'b0010, 4'b1001, 0, 4'b1110, 7'b0000010, 1'b0});
    vecs.push_back('{16'h3456, 4'b0010, 4'b1001, 1, 4'b1111, 7'b1111111, 1'b1});
    vecs.push_back('{16'h3456, 4'b0010, 4'b1001, 3, 4'b0111, 7'b0110000, 1'b0});
    vecs.push_back('{16'h789B, 4'b0000, 4'b0000, 0, 4'b1110, 7'b0000011, 1'b1});
    vecs.push_back('{16'h789B, 4'b0000, 4'b0000, 1, 4'b1101, 7'b0010000, 1'b1});
    vecs.push_back('{16'h789B, 4'b0000, 4'b0000, 2, 4'b1011, 7'b0000000, 1'b1});
    vecs.push_back('{16'h789B, 4'b0000, 4'b0000, 3, 4'b0111, 7'b1111000, 1'b1});
    vecs.push_back('{16'hCDE0, 4'b0000, 4'b0010, 0, 4'b1110, 7'b1000000, 1'b1});
    vecs.push_back('{16'hCDE0, 4'b0000, 4'b0010, 1, 4'b1101, 7'b0000110, 1'b0});
    vecs.push_back('{16'hCDE0, 4'b0000, 4'b0010, 2, 4'b1011, 7'b0100001, 1'b1});
    vecs.push_back('{16'hCDE0, 4'b0000, 4'b0010, 3, 4'b0111, 7'b1000110, 1'b1});
    vecs.push_back('{16'h0005, 4'b0000, 4'b0000, 0, 4'b1110, 7'b0010010, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 4'b0000, 0, 4'b1110, 7'b1000000, 1'b1});
`ifdef LEADING_ZERO_BLANK_EN
    vecs.push_back('{16'h0005, 4'b0000, 4'b0000, 3, 4'b1111, 7'b1111111, 1'b1});
    vecs.push_back('{16'h0005, 4'b0000, 4'b0000, 1, 4'b1111, 7'b1111111, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 4'b0000, 2, 4'b1111, 7'b1111111, 1'b1});
`else
    vecs.push_back('{16'h0005, 4'b0000, 4'b0000, 3, 4'b0111, 7'b1000000, 1'b1});
    vecs.push_back('{16'h0005, 4'b0000, 4'b0000, 1, 4'b1101, 7'b1000000, 1'b1});
    vecs.push_back('{16'h0000, 4'b0000, 4'b0000, 2, 4'b1011, 7'b1000000, 1'b1});
`endif

    // Reset state and the first, dark frame.
    reset_n = 1'b0;
    digits  = 16'h12AF;
    blank   = 4'b0000;
    dp      = 4'b0100;
    freeze  = 1'b0;
    repeat (2) @(negedge clk);
    check_slot("reset", 4'hF, 7'h7F, 1'b1);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    first_frame("first");
    check_slot("first_load_slot0", 4'b1110, 7'b0001110, 1'b1);

    // Table-driven display vectors.
    foreach (vecs[i]) begin
      digits = vecs[i].digits;
      blank  = vecs[i].blank;
      dp     = vecs[i].dp;
      wait_frame($sformatf("vec%0d", i));
      step(4 * vecs[i].slot);
      check_slot($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dpn);
    end

    // Freeze holds the 1234 frame while the inputs change to FFFF.
    digits = 16'h1234;
    blank  = 4'b0000;
    dp     = 4'b0000;
    wait_frame("frz_load");
    freeze = 1'b1;
    digits = 16'hFFFF;
    begin
      int fd_seen;
      fd_seen = 0;
      for (int k = 0; k < 16; k++) begin
        step(1);
        if (frame_done) fd_seen++;
      end
      check("frz_frame_done_count", 32'(fd_seen), 32'd0);
    end
    check_slot("frz_slot0", 4'b1110, 7'b0011001, 1'b1);
    step(12);
    check_slot("frz_slot3", 4'b0111, 7'b1111001, 1'b1);
    freeze = 1'b0;
    wait_frame("unfrz");
    check_slot("unfrz_slot0", 4'b1110, 7'b0001110, 1'b1);
    step(12);
    check_slot("unfrz_slot3", 4'b0111, 7'b0001110, 1'b1);

    // Asynchronous reset while digit 2 is on.
    digits = 16'h12AF;
    blank  = 4'b0000;
    dp     = 4'b0100;
    wait_frame("rst_pre");
    step(8);
    check_slot("rst_pre_slot2", 4'b1011, 7'b0100100, 1'b0);
    #1 reset_n = 1'b0;
    #1 check_slot("rst_async", 4'hF, 7'h7F, 1'b1);
    check("rst_async_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    first_frame("rst_post");
    check_slot("rst_post_slot0", 4'b1110, 7'b0001110, 1'b1);
    step(4);
    check_slot("rst_post_slot1", 4'b1101, 7'b0001000, 1'b1);

    check("anode_onehot_violations", 32'(bad_an), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
